// File: rtl/pattern_generator.sv
// pattern_generator: plays a RAM-held pattern on tx_data once or in a loop,
// flagging a programmable word with tx_trigger.
module pattern_generator #(
  parameter int BUF_DEPTH = 1024,
  parameter int ADDR_BITS = $clog2(BUF_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 buf_wr_en,
  input  logic [ADDR_BITS-1:0] buf_wr_addr,
  input  logic [31:0]          buf_wr_data,
  output logic                 buf_wr_err,
  input  logic [ADDR_BITS:0]   cfg_length,
  input  logic [ADDR_BITS:0]   cfg_trig_pos,
  input  logic                 cfg_loop,
  input  logic                 start,
  input  logic                 abort,
  output logic [31:0]          tx_data,
  output logic                 tx_valid,
  output logic                 tx_trigger,
  output logic                 busy,
  output logic                 done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam logic [ADDR_BITS:0] DEPTH_W = (ADDR_BITS+1)'(BUF_DEPTH);
  state_t state_q, state_d;
  logic [ADDR_BITS-1:0] ptr_q, ptr_d, addr_q;
  logic [ADDR_BITS:0] len_q, len_d, trig_q, trig_d;
  logic loop_q, loop_d;
  logic [31:0] mem [BUF_DEPTH];
  logic [31:0] ram_q, tx_data_q;
  logic v1_q, v2_q, t1_q, t2_q, tx_valid_q, tx_trig_q, done_q, wr_err_q;
  logic issue, last, go, drained;
  assign busy       = state_q != IDLE;
  assign issue      = state_q == RUN && !abort;
  assign last       = {1'b0, ptr_q} == len_q - 1'b1;
  assign go         = state_q == IDLE && start && !abort && cfg_length != '0;
  assign drained    = state_q == DRAIN && !v1_q && !v2_q;
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign tx_trigger = tx_trig_q;
  assign done       = done_q;
  assign buf_wr_err = wr_err_q;
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    trig_d  = trig_q;
    loop_d  = loop_q;
    if (go) begin
      state_d = RUN;
      ptr_d   = '0;
      len_d   = cfg_length > DEPTH_W ? DEPTH_W : cfg_length;
      trig_d  = cfg_trig_pos;
      loop_d  = cfg_loop;
    end else if (abort) begin
      state_d = IDLE;
    end else if (state_q == RUN) begin
      ptr_d   = last ? '0 : ptr_q + 1'b1;
      state_d = (last && !loop_q) ? DRAIN : RUN;
    end else if (drained) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      len_q      <= '0;
      trig_q     <= '0;
      loop_q     <= 1'b0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      t1_q       <= 1'b0;
      t2_q       <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_trig_q  <= 1'b0;
      tx_data_q  <= '0;
      done_q     <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      len_q      <= len_d;
      trig_q     <= trig_d;
      loop_q     <= loop_d;
      // flags ride alongside the 2-cycle RAM read; abort flushes every stage
      v1_q       <= issue;
      t1_q       <= issue && {1'b0, ptr_q} == trig_q;
      v2_q       <= v1_q && !abort;
      t2_q       <= t1_q && !abort;
      tx_valid_q <= v2_q && !abort;
      tx_trig_q  <= t2_q && !abort;
      tx_data_q  <= (v2_q && !abort) ? ram_q : '0;
      done_q     <= drained && !abort;
      wr_err_q   <= buf_wr_en && busy;
    end
  end
  always_ff @(posedge clk) begin
    if (buf_wr_en && !busy) mem[buf_wr_addr] <= buf_wr_data;
    addr_q <= ptr_q;
    ram_q  <= mem[addr_q];
  end
endmodule

// File: tb/tb_pattern_generator.sv
// tb_pattern_generator: scoreboard bench; stimulus queues expected words, a monitor pops them.
module tb_pattern_generator;
  localparam int D = 64;
  localparam int AB = $clog2(D);
  logic clk = 0, rst = 1;
  logic buf_wr_en = 0, cfg_loop = 0, start = 0, abort = 0;
  logic [AB-1:0] buf_wr_addr = '0;
  logic [31:0] buf_wr_data = '0;
  logic [AB:0] cfg_length = '0, cfg_trig_pos = '0;
  logic [31:0] tx_data;
  logic tx_valid, tx_trigger, busy, done, buf_wr_err;
  logic [31:0] model [D];
  logic [32:0] expq [$];
  int checks = 0, errors = 0, cyc = 0;
  int n_valid, first_cyc, last_cyc, done_cnt, done_cyc, err_cnt, start_cyc;

  pattern_generator #(.BUF_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr),
    .buf_wr_data(buf_wr_data), .buf_wr_err(buf_wr_err), .cfg_length(cfg_length),
    .cfg_trig_pos(cfg_trig_pos), .cfg_loop(cfg_loop), .start(start), .abort(abort),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_trigger(tx_trigger), .busy(busy), .done(done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    logic [32:0] e;
    #1;
    if (tx_valid) begin
      if (n_valid == 0) first_cyc = cyc;
      last_cyc = cyc;
      n_valid++;
      if (expq.size() == 0) chk("unexpected_word", {32'h0, tx_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        e = expq.pop_front();
        chk("tx_data", tx_data, e[31:0]);
        chk("tx_trigger", tx_trigger, e[32]);
      end
    end else begin
      chk("idle_data", tx_data, 0);
      chk("idle_trigger", tx_trigger, 0);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("busy_at_done", busy, 0);
    end
    if (buf_wr_err) err_cnt++;
  end

  task automatic clr();
    n_valid = 0; first_cyc = 0; last_cyc = 0; done_cnt = 0; done_cyc = 0; err_cnt = 0;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    buf_wr_en = 1; buf_wr_addr = AB'(a); buf_wr_data = d;
    @(posedge clk); #1;
    buf_wr_en = 0;
    model[a] = d;
  endtask

  task automatic run(input int len, input int trig, input bit lp);
    int l;
    l = len > D ? D : len;
    clr();
    cfg_length = (AB+1)'(len); cfg_trig_pos = (AB+1)'(trig); cfg_loop = lp; start = 1;
    if (!lp) for (int i = 0; i < l; i++) expq.push_back({i == trig, model[i]});
    @(posedge clk); #1;
    start = 0;
    start_cyc = cyc;
  endtask

  task automatic wait_done();
    int t = 0;
    while (done_cnt == 0 && t < 2000) begin
      @(posedge clk); #2;
      t++;
    end
    chk("done_seen", done_cnt > 0, 1);
  endtask

  task automatic check_run(input int l);
    chk("first_valid_cycle", first_cyc, start_cyc + 3);
    chk("valid_count", n_valid, l);
    chk("valid_contiguous", last_cyc - first_cyc + 1, l);
    chk("done_cycle", done_cyc, last_cyc + 1);
    chk("done_count", done_cnt, 1);
    chk("queue_empty", expq.size(), 0);
  endtask

  initial begin
    clr();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_wr_err", buf_wr_err, 0);
    // single pass with trigger on word 3
    for (int i = 0; i < 8; i++) wr(i, 32'hA000_0000 + i);
    run(8, 3, 0);
    chk("busy_after_start", busy, 1);
    wait_done();
    check_run(8);
    // loop length 4, abort after 20 cycles: 18 words reach the output
    for (int i = 0; i < 18; i++) expq.push_back({(i % 4) == 0, 32'hA000_0000 + (i % 4)});
    run(4, 0, 1);
    repeat (20) @(posedge clk);
    #1 abort = 1;
    @(posedge clk); #1;
    abort = 0;
    chk("abort_valid", tx_valid, 0);
    chk("abort_busy", busy, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, 0);
    chk("loop_count", n_valid, 18);
    chk("loop_contiguous", last_cyc - first_cyc + 1, 18);
    chk("loop_queue_empty", expq.size(), 0);
    // full buffer, then clamped length
    for (int i = 0; i < D; i++) wr(i, i ^ 32'h5A5A_5A5A);
    run(D, D - 1, 0);
    wait_done();
    check_run(D);
    run(D + 5, D + 6, 0);
    wait_done();
    check_run(D);
    // zero length is ignored
    clr();
    cfg_length = '0; start = 1;
    @(posedge clk); #1 start = 0;
    for (int i = 0; i < 6; i++) begin
      chk("len0_busy", busy, 0);
      @(posedge clk); #1;
    end
    chk("len0_valid", n_valid, 0);
    // trig_pos == length never triggers
    run(5, 5, 0);
    wait_done();
    check_run(5);
    // write and restart while busy are dropped
    run(8, 3, 0);
    buf_wr_en = 1; buf_wr_addr = AB'(2); buf_wr_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    buf_wr_en = 0; cfg_length = 3; start = 1;
    @(posedge clk); #1 start = 0;
    wait_done();
    check_run(8);
    chk("wr_err_pulses", err_cnt, 1);
    run(8, 3, 0);
    wait_done();
    check_run(8);
    // async reset mid-playback
    run(8, 3, 0);
    repeat (5) @(posedge clk);
    #3 rst = 1;
    #1;
    chk("arst_valid", tx_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_data", tx_data, 0);
    chk("arst_trigger", tx_trigger, 0);
    expq.delete();
    @(posedge clk); #1 rst = 0;
    run(8, 3, 0);
    wait_done();
    check_run(8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
